// File: rtl/cpu_ctrl_pkg.sv
// Shared types and encodings for the cpu_controller FSM and instruction decoder.
package cpu_ctrl_pkg;

  typedef enum logic [2:0] {
    S_WAIT,
    S_DECODE,
    S_WRITE_IMM,
    S_GET_A,
    S_GET_B,
    S_ALU,
    S_WRITE_REG,
    S_TRAP
  } state_e;

  localparam logic [2:0] OPC_MOV    = 3'b110;
  localparam logic [2:0] OPC_ALU    = 3'b101;
  localparam logic [1:0] OP_MOV_IMM = 2'b10;
  localparam logic [1:0] OP_MOV_REG = 2'b00;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_CMP = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_MVN = 2'b11;

  localparam logic [1:0] VSEL_C     = 2'b00;
  localparam logic [1:0] VSEL_PC    = 2'b01;
  localparam logic [1:0] VSEL_IMM8  = 2'b10;
  localparam logic [1:0] VSEL_MDATA = 2'b11;

  localparam logic [1:0] SH_NONE = 2'b00;
  localparam logic [1:0] SH_LSL  = 2'b01;
  localparam logic [1:0] SH_LSR  = 2'b10;
  localparam logic [1:0] SH_ASR  = 2'b11;

endpackage

// File: rtl/cpu_controller_instr_decoder.sv
// Combinational field extraction, instruction class decode and immediate
// sign extension from the execute copy of the instruction register.
module instr_decoder
  import cpu_ctrl_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int RW    = 3
) (
  input  logic [WIDTH-1:0] xr,
  output logic [RW-1:0]    rn,
  output logic [RW-1:0]    rd,
  output logic [RW-1:0]    rm,
  output logic [1:0]       sh,
  output logic [1:0]       op,
  output logic             is_movi,
  output logic             is_movr,
  output logic             is_illegal,
  output logic [WIDTH-1:0] sximm5,
  output logic [WIDTH-1:0] sximm8
);

  logic [2:0] opcode;
  logic       is_alu;

  always_comb begin
    opcode     = xr[15:13];
    op         = xr[12:11];
    rn         = xr[8 +: RW];
    rd         = xr[5 +: RW];
    sh         = xr[4:3];
    rm         = xr[0 +: RW];
    is_movi    = (opcode == OPC_MOV) && (op == OP_MOV_IMM);
    is_movr    = (opcode == OPC_MOV) && (op == OP_MOV_REG);
    is_alu     = (opcode == OPC_ALU);
    is_illegal = !(is_movi || is_movr || is_alu);
    sximm5     = {{(WIDTH-5){xr[4]}}, xr[4:0]};
    sximm8     = {{(WIDTH-8){xr[7]}}, xr[7:0]};
  end

endmodule

// File: rtl/cpu_controller.sv
// Moore FSM + IR/XR instruction registers sequencing the register/shifter/ALU
// datapath. Optional illegal-instruction trap state enabled by ILLEGAL_TRAP_EN.
module cpu_controller
  import cpu_ctrl_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int RW    = 3
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             s,
  input  logic             load,
  input  logic [WIDTH-1:0] in,
  output logic             w,
  output logic [RW-1:0]    writenum,
  output logic [RW-1:0]    readnum,
  output logic             write,
  output logic             loada,
  output logic             loadb,
  output logic             loadc,
  output logic             loads,
  output logic             asel,
  output logic             bsel,
  output logic [1:0]       vsel,
  output logic [1:0]       shift,
  output logic [1:0]       ALUop,
  output logic [WIDTH-1:0] sximm5,
  output logic [WIDTH-1:0] sximm8,
  output logic             err
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] ir_q, ir_d;
  logic [WIDTH-1:0] xr_q, xr_d;

  logic [RW-1:0] rn, rd, rm;
  logic [1:0]    sh, op;
  logic          is_movi, is_movr, is_illegal;

  instr_decoder #(.WIDTH(WIDTH), .RW(RW)) u_dec (
    .xr         (xr_q),
    .rn         (rn),
    .rd         (rd),
    .rm         (rm),
    .sh         (sh),
    .op         (op),
    .is_movi    (is_movi),
    .is_movr    (is_movr),
    .is_illegal (is_illegal),
    .sximm5     (sximm5),
    .sximm8     (sximm8)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= S_WAIT;
      ir_q    <= '0;
      xr_q    <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      xr_q    <= xr_d;
    end
  end

  // XR snapshots IR only when leaving WAIT, so IR reloads mid-instruction are harmless.
  always_comb begin
    ir_d = load ? in : ir_q;
    xr_d = ((state_q == S_WAIT) && s) ? ir_q : xr_q;
  end

  always_comb begin
    state_d  = state_q;
    w        = 1'b0;
    writenum = '0;
    readnum  = '0;
    write    = 1'b0;
    loada    = 1'b0;
    loadb    = 1'b0;
    loadc    = 1'b0;
    loads    = 1'b0;
    asel     = 1'b0;
    bsel     = 1'b0;
    vsel     = VSEL_C;
    shift    = SH_NONE;
    ALUop    = ALU_ADD;
    err      = 1'b0;

    case (state_q)
      S_WAIT: begin
        w = 1'b1;
        if (s) state_d = S_DECODE;
      end
      S_DECODE: begin
        if (is_illegal) begin
`ifdef ILLEGAL_TRAP_EN
          state_d = S_TRAP;
`else
          state_d = S_WAIT;
`endif
        end else if (is_movi) begin
          state_d = S_WRITE_IMM;
        end else if (is_movr) begin
          state_d = S_GET_B;
        end else begin
          state_d = S_GET_A;
        end
      end
      S_WRITE_IMM: begin
        writenum = rn;
        vsel     = VSEL_IMM8;
        write    = 1'b1;
        state_d  = S_WAIT;
      end
      S_GET_A: begin
        readnum = rn;
        loada   = 1'b1;
        state_d = S_GET_B;
      end
      S_GET_B: begin
        readnum = rm;
        loadb   = 1'b1;
        state_d = S_ALU;
      end
      S_ALU: begin
        bsel  = 1'b0;
        shift = sh;
        if (is_movr) begin
          asel    = 1'b1;
          ALUop   = ALU_ADD;
          loadc   = 1'b1;
          state_d = S_WRITE_REG;
        end else if (op == ALU_CMP) begin
          ALUop   = op;
          loads   = 1'b1;
          state_d = S_WAIT;
        end else begin
          ALUop   = op;
          loadc   = 1'b1;
          state_d = S_WRITE_REG;
        end
      end
      S_WRITE_REG: begin
        writenum = rd;
        vsel     = VSEL_C;
        write    = 1'b1;
        state_d  = S_WAIT;
      end
      S_TRAP: begin
`ifdef ILLEGAL_TRAP_EN
        err = 1'b1;
`else
        state_d = S_WAIT;
`endif
      end
      default: state_d = S_WAIT;
    endcase
  end

endmodule

// File: tb/tb_cpu_controller.sv
// Directed scoreboard bench for cpu_controller: expected per-cycle control
// vectors are queued per instruction and popped after each clock edge.
module tb_cpu_controller;

  typedef struct packed {
    logic       w;
    logic [2:0] writenum;
    logic [2:0] readnum;
    logic       write;
    logic       loada;
    logic       loadb;
    logic       loadc;
    logic       loads;
    logic       asel;
    logic       bsel;
    logic [1:0] vsel;
    logic [1:0] shift;
    logic [1:0] aluop;
    logic       err;
  } ctrl_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        s;
  logic        load;
  logic [15:0] in_w;
  logic        w;
  logic [2:0]  writenum, readnum;
  logic        write, loada, loadb, loadc, loads, asel, bsel;
  logic [1:0]  vsel, shift, aluop;
  logic [15:0] sximm5, sximm8;
  logic        err;

  ctrl_t sb[$];
  int    n_vec = 0;
  int    n_bad = 0;

  cpu_controller #(.WIDTH(16), .RW(3)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .s        (s),
    .load     (load),
    .in       (in_w),
    .w        (w),
    .writenum (writenum),
    .readnum  (readnum),
    .write    (write),
    .loada    (loada),
    .loadb    (loadb),
    .loadc    (loadc),
    .loads    (loads),
    .asel     (asel),
    .bsel     (bsel),
    .vsel     (vsel),
    .shift    (shift),
    .ALUop    (aluop),
    .sximm5   (sximm5),
    .sximm8   (sximm8),
    .err      (err)
  );

  always #5 clk = ~clk;

  function automatic ctrl_t zero_v();
    ctrl_t v;
    v = '0;
    return v;
  endfunction

  function automatic ctrl_t idle_v();
    ctrl_t v;
    v = '0;
    v.w = 1'b1;
    return v;
  endfunction

  function automatic ctrl_t observed();
    ctrl_t v;
    v.w = w; v.writenum = writenum; v.readnum = readnum; v.write = write;
    v.loada = loada; v.loadb = loadb; v.loadc = loadc; v.loads = loads;
    v.asel = asel; v.bsel = bsel; v.vsel = vsel; v.shift = shift;
    v.aluop = aluop; v.err = err;
    return v;
  endfunction

  function automatic logic [15:0] sx5(input logic [15:0] x);
    return {{11{x[4]}}, x[4:0]};
  endfunction

  function automatic logic [15:0] sx8(input logic [15:0] x);
    return {{8{x[7]}}, x[7:0]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_pop(input string tag);
    ctrl_t e;
    if (sb.size() == 0) begin
      n_vec++;
      n_bad++;
      $error("FAIL %s observed=scoreboard_empty expected=entry", tag);
    end else begin
      e = sb.pop_front();
      check(tag, 32'(observed()), 32'(e));
    end
  endtask

  // Expected control vector after each edge, starting at the s-sampling edge.
  task automatic push_program(input logic [15:0] ins);
    ctrl_t v;
    logic [2:0] opc;
    logic [1:0] op;
    opc = ins[15:13];
    op  = ins[12:11];
    sb.push_back(zero_v());
    if (opc == 3'b110 && op == 2'b10) begin
      v = zero_v(); v.writenum = ins[10:8]; v.vsel = 2'b10; v.write = 1'b1;
      sb.push_back(v);
    end else if (opc == 3'b110 && op == 2'b00) begin
      v = zero_v(); v.readnum = ins[2:0]; v.loadb = 1'b1;
      sb.push_back(v);
      v = zero_v(); v.asel = 1'b1; v.shift = ins[4:3]; v.loadc = 1'b1;
      sb.push_back(v);
      v = zero_v(); v.writenum = ins[7:5]; v.write = 1'b1;
      sb.push_back(v);
    end else if (opc == 3'b101) begin
      v = zero_v(); v.readnum = ins[10:8]; v.loada = 1'b1;
      sb.push_back(v);
      v = zero_v(); v.readnum = ins[2:0]; v.loadb = 1'b1;
      sb.push_back(v);
      v = zero_v(); v.shift = ins[4:3]; v.aluop = op;
      v.loadc = (op != 2'b01); v.loads = (op == 2'b01);
      sb.push_back(v);
      if (op != 2'b01) begin
        v = zero_v(); v.writenum = ins[7:5]; v.write = 1'b1;
        sb.push_back(v);
      end
    end else begin
`ifdef ILLEGAL_TRAP_EN
      v = zero_v(); v.err = 1'b1;
      for (int i = 0; i < 4; i++) sb.push_back(v);
      return;
`endif
    end
    sb.push_back(idle_v());
  endtask

  task automatic load_ir(input logic [15:0] ins);
    load = 1'b1;
    in_w = ins;
    tick();
    load = 1'b0;
    check("load_idle", 32'(observed()), 32'(idle_v()));
  endtask

  // Runs the instruction currently in IR; optional disturbance reloads IR and
  // re-asserts s on the edge after the start.
  task automatic run(input string tag, input logic [15:0] ins, input bit disturb,
                     input logic [15:0] dis_in);
    int n;
    push_program(ins);
    s = 1'b1;
    tick();
    s = 1'b0;
    check({tag, "_sximm8"}, 32'(sximm8), 32'(sx8(ins)));
    check({tag, "_sximm5"}, 32'(sximm5), 32'(sx5(ins)));
    check_pop({tag, "_decode"});
    n = 0;
    while (sb.size() > 0 && n < 10) begin
      if (disturb && n == 0) begin
        load = 1'b1;
        in_w = dis_in;
        s    = 1'b1;
      end
      tick();
      load = 1'b0;
      s    = 1'b0;
      check_pop($sformatf("%s_cyc%0d", tag, n + 2));
      n++;
    end
    if (sb.size() > 0) begin
      n_vec++;
      n_bad++;
      $error("FAIL %s_timeout observed=%0d_pending expected=0", tag, sb.size());
      sb.delete();
    end
  endtask

  initial begin
    reset_n = 1'b0;
    s       = 1'b0;
    load    = 1'b0;
    in_w    = '0;
    tick();
    tick();
    check("reset_ctrl", 32'(observed()), 32'(idle_v()));
    check("reset_sximm8", 32'(sximm8), 32'h0);
    reset_n = 1'b1;

    load_ir(16'hD007);
    run("movi_r0", 16'hD007, 1'b0, 16'h0);
    load_ir(16'hD1FE);
    run("movi_r1", 16'hD1FE, 1'b0, 16'h0);
    load_ir(16'hA148);
    run("add", 16'hA148, 1'b0, 16'h0);
    load_ir(16'hA801);
    run("cmp", 16'hA801, 1'b0, 16'h0);

    // IR reload and stray s while busy must not affect the running MOV.
    load_ir(16'hC0B3);
    run("movr_dist", 16'hC0B3, 1'b1, 16'hA801);
    run("cmp_after", 16'hA801, 1'b0, 16'h0);

    load_ir(16'hB39E);
    run("and", 16'hB39E, 1'b0, 16'h0);
    load_ir(16'hB8E5);
    run("mvn", 16'hB8E5, 1'b0, 16'h0);

    // Reset while in GET_B aborts with no write afterwards.
    load_ir(16'hA148);
    push_program(16'hA148);
    s = 1'b1;
    tick();
    s = 1'b0;
    check_pop("abort_decode");
    tick();
    check_pop("abort_get_a");
    tick();
    check_pop("abort_get_b");
    sb.delete();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    check("abort_reset", 32'(observed()), 32'(idle_v()));
    check("abort_xr_clear", 32'(sximm5), 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("abort_idle%0d", i), 32'(observed()), 32'(idle_v()));
    end

    load_ir(16'hE000);
    run("illegal", 16'hE000, 1'b1, 16'hD007);
`ifdef ILLEGAL_TRAP_EN
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    check("trap_reset", 32'(observed()), 32'(idle_v()));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
